dual_issue_scheduler: RTL

- Sits between FI_stage and ID_stage of the dual-issue MIPS32 core.
- Buffers fetched instruction pairs in a 4-entry in-order queue and decides each cycle whether to issue 0, 1 or 2 instructions into the two ID slots.
- Issue decisions enforce pairing and hazard rules that the EX/MA bypass network cannot resolve: intra-pair RAW/WAW, load-use, and branch isolation.
- Also provides flush handling and saturating performance counters.

---
 rtl/dual_issue_scheduler_if.sv | 34 +++
 rtl/dual_issue_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-to-decode handshake bundle for the dual-issue scheduler.
// master: fetch side / environment, slave: the scheduler itself.
interface dual_issue_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       in_valid;
  logic [31:0]      in_inst1;
  logic [31:0]      in_inst2;
  logic [31:0]      in_pc1;
  logic [31:0]      in_pc2;
  logic             in_ready;
  logic             hold;
  logic             flush;
  logic             out_valid1;
  logic             out_valid2;
  logic [31:0]      out_inst1;
  logic [31:0]      out_inst2;
  logic [31:0]      out_pc1;
  logic [31:0]      out_pc2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] dual_cnt;

  modport master (
    output in_valid, in_inst1, in_inst2, in_pc1, in_pc2, hold, flush,
    input  in_ready, out_valid1, out_valid2, out_inst1, out_inst2,
           out_pc1, out_pc2, stall_cnt, dual_cnt
  );

  modport slave (
    input  in_valid, in_inst1, in_inst2, in_pc1, in_pc2, hold, flush,
    output in_ready, out_valid1, out_valid2, out_inst1, out_inst2,
           out_pc1, out_pc2, stall_cnt, dual_cnt
  );
endinterface

// File: rtl/dual_issue_scheduler.sv
// In-order issue queue between FI and ID: buffers fetched pairs and issues
// 0, 1 or 2 instructions per cycle subject to pairing and hazard rules.
module dual_issue_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input logic                  CLK,
  input logic                  RST,
  dual_issue_scheduler_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  function automatic logic reads_reg(input logic [31:0] x, input logic [4:0] r);
    logic rs_used;
    logic rt_used;
    rs_used = 1'b1;
    rt_used = 1'b0;
    case (x[31:26])
      6'h00, 6'h2B, 6'h04, 6'h05: rt_used = 1'b1;
      6'h02:                      rs_used = 1'b0;
      default: ;
    endcase
    return (rs_used && x[25:21] == r) || (rt_used && x[20:16] == r);
  endfunction

  // Destination register; 0 means no write (including writes to $0).
  function automatic logic [4:0] dst_of(input logic [31:0] x);
    case (x[31:26])
      6'h00:                      return x[15:11];
      6'h2B, 6'h04, 6'h05, 6'h02: return 5'd0;
      default:                    return x[20:16];
    endcase
  endfunction

  function automatic logic is_load(input logic [31:0] x);
    return x[31:26] == 6'h23;
  endfunction

  function automatic logic is_mem(input logic [31:0] x);
    return x[31:26] == 6'h23 || x[31:26] == 6'h2B;
  endfunction

  function automatic logic is_branch(input logic [31:0] x);
    return x[31:26] == 6'h04 || x[31:26] == 6'h05 || x[31:26] == 6'h02;
  endfunction

  function automatic logic load_use(input logic [31:0] x,
                                    input logic v1, input logic [31:0] i1,
                                    input logic v2, input logic [31:0] i2);
    return (v1 && is_load(i1) && dst_of(i1) != 5'd0 && reads_reg(x, dst_of(i1))) ||
           (v2 && is_load(i2) && dst_of(i2) != 5'd0 && reads_reg(x, dst_of(i2)));
  endfunction

  logic [31:0]      q_inst [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [1:0]       n_push, n_pop;
  logic             issue_a, issue_b;
  logic [31:0]      inst_a, inst_b, pc_a, pc_b;
  logic [4:0]       dst_a, dst_b;
  logic             ov1, ov2;
  logic [31:0]      oi1, oi2, op1, op2;
  logic [CNT_W-1:0] stall_q, dual_q;
  logic             in_ready;

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign inst_a   = q_inst[head];
  assign inst_b   = q_inst[head + PW'(1)];
  assign pc_a     = q_pc[head];
  assign pc_b     = q_pc[head + PW'(1)];
  assign dst_a    = dst_of(inst_a);
  assign dst_b    = dst_of(inst_b);

  // Accepted push width; 2'b10 is treated as no push.
  always_comb begin
    n_push = 2'd0;
    if (in_ready && !bus.flush) begin
      case (bus.in_valid)
        2'b01:   n_push = 2'd1;
        2'b11:   n_push = 2'd2;
        default: n_push = 2'd0;
      endcase
    end
  end

  // Issue decision on queue head (A) and its successor (B).
  always_comb begin
    issue_a = 1'b0;
    issue_b = 1'b0;
    if (count != '0 && !bus.hold && !bus.flush &&
        !load_use(inst_a, ov1, oi1, ov2, oi2))
      issue_a = 1'b1;
    if (issue_a && count >= CW'(2) &&
        !is_branch(inst_a) && !is_branch(inst_b) &&
        !(dst_a != 5'd0 && reads_reg(inst_b, dst_a)) &&
        !(dst_a != 5'd0 && dst_a == dst_b) &&
        !(is_mem(inst_a) && is_mem(inst_b)) &&
        !load_use(inst_b, ov1, oi1, ov2, oi2))
      issue_b = 1'b1;
    n_pop = issue_b ? 2'd2 : (issue_a ? 2'd1 : 2'd0);
  end

  // Queue storage writes; slots beyond count are don't-care.
  always_ff @(posedge CLK) begin
    if (n_push != 2'd0) begin
      q_inst[tail] <= bus.in_inst1;
      q_pc[tail]   <= bus.in_pc1;
    end
    if (n_push == 2'd2) begin
      q_inst[tail + PW'(1)] <= bus.in_inst2;
      q_pc[tail + PW'(1)]   <= bus.in_pc2;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(n_push);
      count <= count + CW'(n_push) - CW'(n_pop);
    end
  end

  // Presented ID slots; hold freezes them, unissued slots become bubbles.
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      ov1 <= 1'b0;
      ov2 <= 1'b0;
      oi1 <= '0;
      oi2 <= '0;
      op1 <= '0;
      op2 <= '0;
    end else if (!bus.hold) begin
      ov1 <= issue_a;
      ov2 <= issue_b;
      oi1 <= issue_a ? inst_a : '0;
      op1 <= issue_a ? pc_a   : '0;
      oi2 <= issue_b ? inst_b : '0;
      op2 <= issue_b ? pc_b   : '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      dual_q  <= '0;
    end else begin
      if (count != '0 && !bus.hold && !bus.flush && n_pop == 2'd0 && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (n_pop == 2'd2 && dual_q != '1)
        dual_q <= dual_q + CNT_W'(1);
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid1 = ov1;
  assign bus.out_valid2 = ov2;
  assign bus.out_inst1  = oi1;
  assign bus.out_inst2  = oi2;
  assign bus.out_pc1    = op1;
  assign bus.out_pc2    = op2;
  assign bus.stall_cnt  = stall_q;
  assign bus.dual_cnt   = dual_q;
endmodule
